// File: rtl/calc_disp_pkg.sv
// Shared display constants: seven-segment codes (active-low, {a,b,c,d,e,f,g})
// and the nibble-to-segment lookup used by the display stage.
package calc_disp_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] LED_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment code.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup, no state.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Free-running 8-digit multiplexed seven-segment driver with per-slot guard,
// leading-zero blanking and decimal-point mask. All outputs are registered.
module seg7_scan_driver
    import calc_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 200000,
    parameter int unsigned GUARD    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic [7:0]  dp_mask,
    input  logic        blank_zero,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    localparam int unsigned   PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescale;
    logic [PW-1:0] prescale_next;
    logic          slot_start;
    logic [2:0]    idx;
    logic          started;

    logic [31:0]   disp_reg;
    logic [7:0]    dp_reg;
    logic [31:0]   cur_data;
    logic [7:0]    cur_dp;

    logic [3:0]    fresh_nib;
    logic          fresh_blank;

    logic [3:0]    snap_nib;
    logic          snap_dp;
    logic          snap_blank;
    logic [2:0]    snap_idx;

    logic [3:0]    sel_nib;
    logic          sel_dp;
    logic          sel_blank;
    logic [2:0]    sel_idx;

    logic          show;
    logic [6:0]    seg_code;
    logic [6:0]    seg_q;

    // Slot timing, load bypass and the per-slot digit selection.
    // On a slot start the freshly selected digit bypasses the snapshot so the
    // first cycle of the slot is already correct even when GUARD is zero.
    always_comb begin
        slot_start    = (prescale == LAST);
        prescale_next = slot_start ? '0 : prescale + 1'b1;
        cur_data      = data_valid ? data_in : disp_reg;
        cur_dp        = data_valid ? dp_mask : dp_reg;
        fresh_nib     = cur_data[{idx, 2'b00} +: 4];
        fresh_blank   = blank_zero && (idx != 3'd0) &&
                        ((cur_data >> {idx, 2'b00}) == 32'h0);
        sel_nib       = slot_start ? fresh_nib   : snap_nib;
        sel_dp        = slot_start ? cur_dp[idx] : snap_dp;
        sel_blank     = slot_start ? fresh_blank : snap_blank;
        sel_idx       = slot_start ? idx         : snap_idx;
        show          = (started || slot_start) &&
                        (32'(prescale_next) >= GUARD) && !sel_blank;
    end

    seg7_decode u_decode (
        .nibble (sel_nib),
        .seg    (seg_code)
    );

    // Prescaler and digit index; idx names the digit shown in the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            idx      <= '0;
            started  <= 1'b0;
        end else begin
            prescale <= prescale_next;
            if (slot_start) begin
                idx     <= idx + 3'd1;
                started <= 1'b1;
            end
        end
    end

    // Display and dp registers loaded by the data_valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= '0;
            dp_reg   <= '0;
        end else if (data_valid) begin
            disp_reg <= data_in;
            dp_reg   <= dp_mask;
        end
    end

    // Per-slot snapshot so mid-slot loads never disturb the digit on screen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_nib   <= '0;
            snap_dp    <= 1'b0;
            snap_blank <= 1'b0;
            snap_idx   <= '0;
        end else if (slot_start) begin
            snap_nib   <= fresh_nib;
            snap_dp    <= cur_dp[idx];
            snap_blank <= fresh_blank;
            snap_idx   <= idx;
        end
    end

    // Registered display outputs: dark during guard, blank digits and pre-start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_en <= LED_OFF;
            seg_q  <= SEG_OFF;
            led_dp <= 1'b1;
        end else if (show) begin
            led_en <= ~(8'h01 << sel_idx);
            seg_q  <= seg_code;
            led_dp <= ~sel_dp;
        end else begin
            led_en <= LED_OFF;
            seg_q  <= SEG_OFF;
            led_dp <= 1'b1;
        end
    end

    assign {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg} = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: slot-level behavioural model with a
// per-cycle compare, directed literal checks and a randomized load phase.
module tb_seg7_scan_driver;

    localparam int unsigned DIV = 4;
    localparam int unsigned GRD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic [7:0]  dp_mask = '0;
    logic        blank_zero = 1'b0;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg;
    logic        led_dp;
    logic [6:0]  segs;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    int unsigned cyc_cnt = 0;

    seg7_scan_driver #(
        .SCAN_DIV (DIV),
        .GUARD    (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .dp_mask    (dp_mask),
        .blank_zero (blank_zero),
        .led_en     (led_en),
        .led_ca     (led_ca),
        .led_cb     (led_cb),
        .led_cc     (led_cc),
        .led_cd     (led_cd),
        .led_ce     (led_ce),
        .led_cf     (led_cf),
        .led_cg     (led_cg),
        .led_dp     (led_dp)
    );

    always #5 clk = ~clk;

    assign segs = {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg};

    always @(posedge clk) cyc_cnt++;

    // Segment codes {a..g}, active-low, written out from the display table.
    logic [6:0] segtab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: cycles since reset release, slot count, and what the
    // current slot was told to show when it started.
    int unsigned m_t = 0;
    int unsigned m_slots = 0;
    int unsigned m_cyc = 0;
    int unsigned m_digit = 0;
    bit          m_have = 1'b0;
    bit          m_blank = 1'b0;
    bit          m_dpbit = 1'b0;
    logic [3:0]  m_nib = '0;
    logic [31:0] m_disp = '0;
    logic [7:0]  m_dpreg = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] eff;
        logic [7:0]  effdp;
        if (!rst_n) begin
            m_t = 0; m_slots = 0; m_cyc = 0; m_digit = 0;
            m_have = 1'b0; m_blank = 1'b0; m_dpbit = 1'b0; m_nib = '0;
            m_disp = '0; m_dpreg = '0;
        end else begin
            eff   = data_valid ? data_in : m_disp;
            effdp = data_valid ? dp_mask : m_dpreg;
            if (m_t % DIV == DIV - 1) begin
                m_have  = 1'b1;
                m_digit = m_slots % 8;
                m_slots++;
                m_nib   = 4'((eff >> (4 * m_digit)) & 32'hF);
                m_dpbit = effdp[m_digit];
                m_blank = blank_zero && (m_digit != 0) &&
                          ((eff >> (4 * m_digit)) == 32'h0);
                m_cyc   = 1;
            end else if (m_have) begin
                m_cyc++;
            end
            if (data_valid) begin
                m_disp  = data_in;
                m_dpreg = dp_mask;
            end
            m_t++;
        end
    end

    function automatic logic [15:0] model_out();
        if (!m_have || m_cyc <= GRD || m_blank)
            return {8'hFF, 7'h7F, 1'b1};
        return {~(8'h01 << m_digit), segtab[m_nib], ~m_dpbit};
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({led_en, segs, led_dp} !== model_out()) begin
                failures++;
                $display("FAIL scan_cycle t=%0d actual=%h required=%h",
                         cyc_cnt, {led_en, segs, led_dp}, model_out());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to the first active cycle of the next slot for digit d.
    task automatic wait_slot(input int unsigned d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_have && m_digit == d && m_cyc == GRD + 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL wait_slot digit=%0d actual=timeout required=slot", d);
        end
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] dp);
        data_in    = v;
        dp_mask    = dp;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  t2seg [8];
        int unsigned t0;
        int          n;
        t2seg = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001111,
                  7'b0000001, 7'b0000110, 7'b0000001, 7'b0000001};

        // 1: reset and first frame
        repeat (3) @(negedge clk);
        chk("rst_en", led_en, 8'hFF);
        chk("rst_seg", segs, 7'h7F);
        chk("rst_dp", led_dp, 1'b1);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pre_wrap_en", led_en, 8'hFF);
        end
        for (int unsigned d = 0; d < 8; d++) begin
            wait_slot(d);
            chk("frame_en", led_en, ~(32'h1 << d) & 32'hFF);
        end

        // 2: plain digits, no blanking
        blank_zero = 1'b0;
        load(32'h00301321, 8'h00);
        for (int unsigned d = 0; d < 8; d++) begin
            wait_slot(d);
            chk("t2_seg", segs, t2seg[d]);
            chk("t2_dp", led_dp, 1'b1);
        end

        // 3: leading-zero blanking, slot period unchanged
        blank_zero = 1'b1;
        load(32'h0000000A, 8'h00);
        wait_slot(0);
        t0 = cyc_cnt;
        chk("t3_en0", led_en, 8'hFE);
        chk("t3_seg0", segs, 7'b0001000);
        for (int unsigned d = 1; d < 8; d++) begin
            wait_slot(d);
            chk("t3_blank_en", led_en, 8'hFF);
        end
        wait_slot(0);
        chk("t3_frame_len", cyc_cnt - t0, 8 * DIV);

        // 4: value zero with dp mask
        load(32'h00000000, 8'h03);
        wait_slot(0);
        chk("t4_seg0", segs, 7'b0000001);
        chk("t4_dp0", led_dp, 1'b0);
        wait_slot(1);
        chk("t4_en1", led_en, 8'hFF);
        chk("t4_dp1", led_dp, 1'b1);

        // 5: mid-slot load leaves current digit alone
        blank_zero = 1'b0;
        wait_slot(2);
        chk("t5_pre_seg", segs, 7'b0000001);
        load(32'h00003840, 8'h00);
        chk("t5_hold_en", led_en, 8'hFB);
        chk("t5_hold_seg", segs, 7'b0000001);
        @(negedge clk);
        chk("t5_hold_seg2", segs, 7'b0000001);
        wait_slot(3);
        chk("t5_d3_en", led_en, 8'hF7);
        chk("t5_d3_seg", segs, 7'b0000110);
        wait_slot(1);
        chk("t5_d1_seg", segs, 7'b1001100);
        wait_slot(2);
        chk("t5_d2_seg", segs, 7'b0000000);

        // 6: asynchronous reset mid-slot
        wait_slot(4);
        chk("t6_pre_en", led_en, 8'hEF);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_en", led_en, 8'hFF);
        chk("t6_async_seg", segs, 7'h7F);
        chk("t6_async_dp", led_dp, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (led_en == 8'hFF && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_en", led_en, 8'hFE);

        // Randomized loads, masks and blanking
        repeat (3000) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 5) == 0);
            data_in    = $urandom >> ($urandom_range(0, 8) * 4);
            dp_mask    = 8'($urandom);
            if ($urandom_range(0, 30) == 0) blank_zero = ~blank_zero;
        end
        @(negedge clk);
        data_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage of the calculator. Captures the 32-bit hex result produced by the calculator core and time-multiplexes it onto the 8-digit common-enable seven-segment display (led_en, led_ca..led_cg, led_dp). Scanning is free-running, with a programmable slot length, per-slot ghosting guard, optional leading-zero blanking and a per-digit decimal-point mask.

Parameters:
SCAN_DIV, 200000, clk cycles per digit slot (2 ms at 100 MHz); legal range 4..2^24.
GUARD, 2, cycles at the start of each slot with all digits disabled; must be < SCAN_DIV.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
data_in  in  32  hex value to display; digit i = data_in[4i+3:4i]
data_valid  in  1  single-cycle load strobe for data_in and dp_mask
dp_mask  in  8  bit i = 1 lights the decimal point of digit i
blank_zero  in  1  1 = suppress leading zero digits (level, sampled each slot)
led_en  out  8  digit enables, active-low; bit 0 = rightmost digit
led_ca..led_cg  out  1 each  segments a..g, active-low
led_dp  out  1  decimal point, active-low

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on rst_n. All outputs are registered.
- Reset values:
  - led_en = 8'hFF; led_ca..led_cg = 1; led_dp = 1.
  - Prescaler = 0; digit index = 0.
  - Display register = 32'h0; dp register = 8'h00.
- Load:
  - On a data_valid cycle, the display register and dp register take data_in and dp_mask at the next edge.
  - Digits already on screen are not changed mid-slot. The new value appears from the next slot start.
  - If data_valid arrives in the same cycle as a slot start, the new value is used for that slot.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - slot_start = (prescaler == SCAN_DIV-1). On slot_start the digit index increments, wrapping 7 -> 0.
- Slot outputs (slot = the SCAN_DIV cycles following a slot_start):
  - Guard: for the first GUARD cycles of the slot, led_en = 8'hFF and all segments = 1.
  - Active part: for the remaining cycles, led_en = ~(8'h01 << idx).
  - Segments and dp come from a nibble/dp snapshot taken at slot_start, so they are stable for the whole slot.
  - The very first slot after reset shows digit 0 once the prescaler first wraps. Before that, outputs hold their reset values.
- Leading-zero blanking (blank_zero = 1):
  - A digit is blank when it and every higher digit are 0.
  - Digit 0 is never blank, so value 0 shows a single "0".
  - A blank digit keeps led_en = 8'hFF for its whole slot, but scan timing is unchanged.
  - dp on a blank digit is also suppressed.
- Segment map {a,b,c,d,e,f,g}, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-scan: outputs go to reset values immediately (asynchronous). The scan restarts from digit 0 after release.
- Latency: from slot_start to valid digit outputs is GUARD+1 cycles.

Decomposition:
- Shared package (calc_disp_pkg):
  - Seven-segment code constants SEG_0..SEG_F and SEG_OFF = 7'h7F.
  - LED_OFF = 8'hFF.
  - Function hex_to_seg(nibble) -> 7-bit code.
- One sub-module: seg7_decode (combinational nibble -> segment code), instantiated once on the snapshot nibble.
- Prescaler, index, blanking and output registers stay in the top module.

Test Plan:
1. Reset check, SCAN_DIV=4, GUARD=1: hold rst_n=0 for 3 cycles, release -> led_en=FF and all segments/dp=1 until the first wrap. Then slots proceed with led_en sequence FE,FD,FB,F7,EF,DF,BF,7F, each active for 3 cycles after 1 guard cycle.
2. Load 32'h00301321, blank_zero=0, dp_mask=0 -> digit values 0..7 = 1,2,3,1,0,3,0,0. Segments per slot = 1001111,0010010,0000110,1001111,0000001,0000110,0000001,0000001; led_dp always 1.
3. Load 32'h0000000A with blank_zero=1 -> only the digit-0 slot enables (led_en=FE, segs=0001000). Slots 1..7 keep led_en=FF; slot period unchanged.
4. Load 32'h00000000 with blank_zero=1, dp_mask=8'h03 -> digit 0 shows 0000001 with led_dp=0. Digit 1 stays blank and its dp is suppressed.
5. Mid-slot load: during the active part of the digit-2 slot, pulse data_valid with 32'h00003840 -> digit-2 outputs unchanged until slot end. The next digit-3 slot shows 3 (0000110); all digits are correct on the next full frame.
6. Assert rst_n=0 during an active slot -> led_en=FF and segments=1 in the same cycle (asynchronous). After release, the first enabled digit is digit 0.
